// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_bus_arbiter
//  Purpose  : Two-port arbiter and strobe sequencer for the shared ROM/RAM bus.
//             Optional macro ROM_WR_ERR_EN: suppresses ROM writes, flags errN.
//  Revision : 1.0  initial release
// ============================================================================
module mem_bus_arbiter #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int FIXED_PRI = 0
) (
    input  logic              clk,
    input  logic              rst_bar,
    input  logic              req0,
    input  logic              we0,
    input  logic              selram0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              ack0,
    output logic              err0,
    input  logic              req1,
    input  logic              we1,
    input  logic              selram1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              ack1,
    output logic              err1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] MAddr,
    inout  wire  [DATA_W-1:0] MData,
    output logic              re_bar,
    output logic              we_bar,
    output logic              ram_en_bar
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCESS  = 2'd1,
        S_CAPTURE = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                owner_q, owner_d;
    logic                last_gnt_q, last_gnt_d;
    logic                we_q, we_d;
    logic                sel_q, sel_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                w_win;
    logic                w_drive;
    logic                w_resp;
    logic                w_err;

    always_ff @(posedge clk) begin
        if (!rst_bar) begin
            state_q    <= S_IDLE;
            owner_q    <= 1'b0;
            last_gnt_q <= 1'b1;
            we_q       <= 1'b0;
            sel_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_gnt_q <= last_gnt_d;
            we_q       <= we_d;
            sel_q      <= sel_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
        end
    end

    // Round-robin favours the port that did not win last time on a tie.
    always_comb begin
        w_win = !req0;
        if (FIXED_PRI == 0 && req0 && req1) begin
            w_win = !last_gnt_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_gnt_d = last_gnt_q;
        we_d       = we_q;
        sel_d      = sel_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    owner_d    = w_win;
                    last_gnt_d = w_win;
                    we_d       = w_win ? we1     : we0;
                    sel_d      = w_win ? selram1 : selram0;
                    addr_d     = w_win ? addr1   : addr0;
                    wdata_d    = w_win ? wdata1  : wdata0;
                    state_d    = S_ACCESS;
                end
            end
            S_ACCESS: state_d = S_CAPTURE;
            S_CAPTURE: begin
                if (!we_q) begin
                    rdata_d = MData;
                end
                state_d = S_RESP;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        re_bar     = 1'b1;
        we_bar     = 1'b1;
        ram_en_bar = 1'b1;
        w_drive    = 1'b0;
        case (state_q)
            S_ACCESS: begin
                if (we_q) begin
`ifdef ROM_WR_ERR_EN
                    if (sel_q) begin
                        we_bar     = 1'b0;
                        ram_en_bar = 1'b0;
                        w_drive    = 1'b1;
                    end
`else
                    we_bar     = 1'b0;
                    ram_en_bar = !sel_q;
                    w_drive    = 1'b1;
`endif
                end else begin
                    re_bar     = 1'b0;
                    ram_en_bar = !sel_q;
                end
            end
            S_CAPTURE: begin
                // Read strobes span two cycles so the registered RAM output is valid here.
                if (!we_q) begin
                    re_bar     = 1'b0;
                    ram_en_bar = !sel_q;
                end
            end
            default: ;
        endcase
    end

`ifdef ROM_WR_ERR_EN
    assign w_err = we_q && !sel_q;
`else
    assign w_err = 1'b0;
`endif

    assign w_resp = (state_q == S_RESP);
    assign gnt0   = (state_q != S_IDLE) && !owner_q;
    assign gnt1   = (state_q != S_IDLE) &&  owner_q;
    assign ack0   = w_resp && !owner_q;
    assign ack1   = w_resp &&  owner_q;
    assign err0   = w_resp && !owner_q && w_err;
    assign err1   = w_resp &&  owner_q && w_err;
    assign rdata  = rdata_q;
    assign MAddr  = addr_q;
    assign MData  = w_drive ? wdata_q : {DATA_W{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_bus_arbiter
//  Purpose  : Directed self-checking bench with ROM/RAM bus models.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_bus_arbiter;

    localparam int TB_FIXED_PRI = 0;
`ifdef ROM_WR_ERR_EN
    localparam int         EXP_RW_WE  = 0;
    localparam int         EXP_RW_ERR = 1;
    localparam logic [7:0] EXP_RW_WD  = 8'h00;
`else
    localparam int         EXP_RW_WE  = 1;
    localparam int         EXP_RW_ERR = 0;
    localparam logic [7:0] EXP_RW_WD  = 8'hEE;
`endif

    logic       clk = 1'b0;
    logic       rst_bar;
    logic       req0, we0, selram0, req1, we1, selram1;
    logic [7:0] addr0, wdata0, addr1, wdata1;
    logic       gnt0, ack0, err0, gnt1, ack1, err1;
    logic [7:0] rdata, MAddr;
    tri1  [7:0] MData;
    logic       re_bar, we_bar, ram_en_bar;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .FIXED_PRI(TB_FIXED_PRI)) dut (
        .clk(clk), .rst_bar(rst_bar),
        .req0(req0), .we0(we0), .selram0(selram0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .ack0(ack0), .err0(err0),
        .req1(req1), .we1(we1), .selram1(selram1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .ack1(ack1), .err1(err1),
        .rdata(rdata), .MAddr(MAddr), .MData(MData),
        .re_bar(re_bar), .we_bar(we_bar), .ram_en_bar(ram_en_bar)
    );

    // Memory models: combinational ROM, registered-read RAM.
    logic [7:0] ram [0:255];
    logic [7:0] ram_dout = 8'h00;
    logic       ram_loaded = 1'b0;

    function automatic logic [7:0] rom_val(input logic [7:0] a);
        return (a == 8'h00) ? 8'h3C : (a ^ 8'h5B);
    endfunction

    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
            ram[0]     <= 8'h5A;
            ram_loaded <= 1'b1;
        end else begin
            if (!ram_en_bar && !we_bar) ram[MAddr] <= MData;
            if (!ram_en_bar && !re_bar) ram_dout <= ram[MAddr];
        end
    end

    assign MData = (!ram_en_bar && !re_bar) ? ram_dout       : 8'hzz;
    assign MData = ( ram_en_bar && !re_bar) ? rom_val(MAddr) : 8'hzz;

    // Observations of one transaction.
    int         o_gnt, o_ack, o_re, o_we, o_ren, o_err, o_other, o_post;
    logic [7:0] o_rd, o_wd, o_addr;

    task automatic run_txn(input int port, input logic we, input logic sel,
                           input logic [7:0] addr, input logic [7:0] wd);
        logic g, a;
        o_gnt = -1; o_ack = -1; o_re = 0; o_we = 0; o_ren = 0; o_err = 0;
        o_other = 0; o_post = 0; o_rd = 8'h00; o_wd = 8'h00; o_addr = 8'h00;
        if (port == 0) begin
            req0 = 1'b1; we0 = we; selram0 = sel; addr0 = addr; wdata0 = wd;
        end else begin
            req1 = 1'b1; we1 = we; selram1 = sel; addr1 = addr; wdata1 = wd;
        end
        for (int c = 1; c <= 12 && o_ack < 0; c++) begin
            @(negedge clk);
            g = (port == 0) ? gnt0 : gnt1;
            a = (port == 0) ? ack0 : ack1;
            if ((port == 0) ? (gnt1 | ack1 | err1) : (gnt0 | ack0 | err0)) o_other++;
            if ((port == 0) ? err0 : err1) o_err++;
            if (g && o_gnt < 0) begin
                o_gnt = c;
                req0 = 1'b0;
                req1 = 1'b0;
            end
            if (!re_bar) o_re++;
            if (!we_bar) begin
                o_we++;
                o_wd = MData;
            end
            if (!ram_en_bar) o_ren++;
            if (c == 1) o_addr = MAddr;
            if (a) begin
                o_ack = c;
                o_rd  = rdata;
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        @(negedge clk);
        o_post = int'(gnt0 | gnt1 | ack0 | ack1);
    endtask

    task automatic test_reset();
        rst_bar = 1'b0;
        req0 = 1'b1; we0 = 1'b0; selram0 = 1'b1; addr0 = 8'h00; wdata0 = 8'h00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if ({re_bar, we_bar, ram_en_bar} !== 3'b111) begin n_bad++;
                $display("FAIL reset_strobes: got %b want 111", {re_bar, we_bar, ram_en_bar}); end
            n_cmp++; if (MData !== 8'hFF) begin n_bad++;
                $display("FAIL reset_mdata_released: got %h want ff (pulled)", MData); end
            n_cmp++; if ({gnt0, gnt1, ack0, ack1, err0, err1} !== 6'b0) begin n_bad++;
                $display("FAIL reset_handshake: got %b want 000000", {gnt0, gnt1, ack0, ack1, err0, err1}); end
        end
        n_cmp++; if ({MAddr, rdata} !== 16'h0000) begin n_bad++;
            $display("FAIL reset_addr_rdata: got %h want 0000", {MAddr, rdata}); end
        rst_bar = 1'b1;
        @(negedge clk);
        n_cmp++; if ({gnt0, gnt1} !== 2'b10) begin n_bad++;
            $display("FAIL first_grant: got %b want 10", {gnt0, gnt1}); end
        req0 = 1'b0;
        for (int i = 0; i < 6 && !ack0; i++) @(negedge clk);
        n_cmp++; if ({ack0, rdata} !== {1'b1, 8'h5A}) begin n_bad++;
            $display("FAIL first_read: got ack=%b rdata=%h want ack=1 rdata=5a", ack0, rdata); end
        @(negedge clk);
    endtask

    task automatic test_ram_write_read();
        run_txn(0, 1'b1, 1'b1, 8'h10, 8'hA5);
        n_cmp++; if ({o_gnt, o_ack} !== {32'sd1, 32'sd3}) begin n_bad++;
            $display("FAIL wr_timing: got gnt@%0d ack@%0d want 1,3", o_gnt, o_ack); end
        n_cmp++; if ({o_we, o_ren, o_re} !== {32'd1, 32'd1, 32'd0}) begin n_bad++;
            $display("FAIL wr_strobes: got we=%0d ren=%0d re=%0d want 1,1,0", o_we, o_ren, o_re); end
        n_cmp++; if ({o_wd, o_rd, ram[8'h10]} !== {8'hA5, 8'h5A, 8'hA5}) begin n_bad++;
            $display("FAIL wr_data: got bus=%h rdata=%h mem=%h want a5,5a,a5", o_wd, o_rd, ram[8'h10]); end
        n_cmp++; if ({o_err, o_other, o_post} !== {32'd0, 32'd0, 32'd0}) begin n_bad++;
            $display("FAIL wr_misc: got err=%0d other=%0d post=%0d want 0,0,0", o_err, o_other, o_post); end
        run_txn(0, 1'b0, 1'b1, 8'h10, 8'h00);
        n_cmp++; if ({o_rd, o_ack} !== {8'hA5, 32'sd3}) begin n_bad++;
            $display("FAIL rd_ram: got rdata=%h ack@%0d want a5,3", o_rd, o_ack); end
        n_cmp++; if ({o_re, o_ren, o_we} !== {32'd2, 32'd2, 32'd0}) begin n_bad++;
            $display("FAIL rd_strobes: got re=%0d ren=%0d we=%0d want 2,2,0", o_re, o_ren, o_we); end
    endtask

    task automatic test_rom_read();
        run_txn(1, 1'b0, 1'b0, 8'h00, 8'h00);
        n_cmp++; if ({o_rd, o_gnt, o_ack} !== {8'h3C, 32'sd1, 32'sd3}) begin n_bad++;
            $display("FAIL rom_rd: got rdata=%h gnt@%0d ack@%0d want 3c,1,3", o_rd, o_gnt, o_ack); end
        n_cmp++; if ({o_re, o_ren, o_other} !== {32'd2, 32'd0, 32'd0}) begin n_bad++;
            $display("FAIL rom_rd_strobes: got re=%0d ren=%0d other=%0d want 2,0,0", o_re, o_ren, o_other); end
    endtask

    task automatic test_addr_boundary();
        run_txn(1, 1'b1, 1'b1, 8'hFF, 8'h81);
        n_cmp++; if ({o_addr, ram[8'hFF]} !== {8'hFF, 8'h81}) begin n_bad++;
            $display("FAIL ff_write: got maddr=%h mem=%h want ff,81", o_addr, ram[8'hFF]); end
        run_txn(1, 1'b0, 1'b1, 8'hFF, 8'h00);
        n_cmp++; if (o_rd !== 8'h81) begin n_bad++;
            $display("FAIL ff_ram_read: got %h want 81", o_rd); end
        run_txn(1, 1'b0, 1'b0, 8'hFF, 8'h00);
        n_cmp++; if (o_rd !== 8'hA4) begin n_bad++;
            $display("FAIL ff_rom_read: got %h want a4", o_rd); end
        run_txn(1, 1'b0, 1'b1, 8'h00, 8'h00);
        n_cmp++; if ({o_addr, o_rd} !== {8'h00, 8'h5A}) begin n_bad++;
            $display("FAIL zero_ram_read: got maddr=%h rdata=%h want 00,5a", o_addr, o_rd); end
    endtask

    task automatic test_contention();
        int         acks[$];
        logic [7:0] rds[$];
        int         both = 0;
        int         exp_p;
        req0 = 1'b1; we0 = 1'b0; selram0 = 1'b1; addr0 = 8'h10;
        req1 = 1'b1; we1 = 1'b0; selram1 = 1'b0; addr1 = 8'h00;
        for (int c = 0; c < 40 && acks.size() < 4; c++) begin
            @(negedge clk);
            if (gnt0 && gnt1) both++;
            if (ack0) begin acks.push_back(0); rds.push_back(rdata); end
            if (ack1) begin acks.push_back(1); rds.push_back(rdata); end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        @(negedge clk);
        n_cmp++; if (acks.size() != 4 || both != 0) begin n_bad++;
            $display("FAIL contention_count: got acks=%0d overlap=%0d want 4,0", acks.size(), both); end
        for (int i = 0; i < 4 && i < acks.size(); i++) begin
            exp_p = (TB_FIXED_PRI != 0) ? 0 : (i % 2);
            n_cmp++; if (acks[i] != exp_p || rds[i] !== ((exp_p == 0) ? 8'hA5 : 8'h3C)) begin n_bad++;
                $display("FAIL contention_%0d: got port=%0d rdata=%h want port=%0d", i, acks[i], rds[i], exp_p); end
        end
    endtask

    task automatic test_rom_write();
        run_txn(0, 1'b1, 1'b0, 8'h05, 8'hEE);
        n_cmp++; if ({o_we, o_err, o_ack} !== {EXP_RW_WE, EXP_RW_ERR, 32'sd3}) begin n_bad++;
            $display("FAIL rom_write: got we=%0d err=%0d ack@%0d want %0d,%0d,3",
                     o_we, o_err, o_ack, EXP_RW_WE, EXP_RW_ERR); end
        n_cmp++; if ({o_ren, o_wd, o_rd} !== {32'd0, EXP_RW_WD, 8'h3C}) begin n_bad++;
            $display("FAIL rom_write_bus: got ren=%0d bus=%h rdata=%h want 0,%h,3c", o_ren, o_wd, o_rd, EXP_RW_WD); end
    endtask

    task automatic test_abort();
        int late = 0;
        req0 = 1'b1; we0 = 1'b1; selram0 = 1'b1; addr0 = 8'h20; wdata0 = 8'h77;
        @(negedge clk);
        n_cmp++; if ({gnt0, we_bar, MAddr, MData} !== {1'b1, 1'b0, 8'h20, 8'h77}) begin n_bad++;
            $display("FAIL abort_access: got gnt=%b we_bar=%b maddr=%h mdata=%h want 1,0,20,77",
                     gnt0, we_bar, MAddr, MData); end
        rst_bar = 1'b0;
        req0 = 1'b0;
        @(negedge clk);
        n_cmp++; if ({re_bar, we_bar, ram_en_bar, MData, gnt0, ack0, rdata} !== {3'b111, 8'hFF, 2'b00, 8'h00}) begin n_bad++;
            $display("FAIL abort_reset: got strobes=%b mdata=%h gnt=%b ack=%b rdata=%h want 111,ff,0,0,00",
                     {re_bar, we_bar, ram_en_bar}, MData, gnt0, ack0, rdata); end
        rst_bar = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (gnt0 | gnt1 | ack0 | ack1) late++;
        end
        n_cmp++; if (late != 0) begin n_bad++;
            $display("FAIL abort_no_ack: got %0d active cycles want 0", late); end
        run_txn(1, 1'b0, 1'b0, 8'h05, 8'h00);
        n_cmp++; if ({o_gnt, o_ack, o_rd} !== {32'sd1, 32'sd3, 8'h5E}) begin n_bad++;
            $display("FAIL after_abort: got gnt@%0d ack@%0d rdata=%h want 1,3,5e", o_gnt, o_ack, o_rd); end
    endtask

    initial begin
        rst_bar = 1'b0;
        req0 = 1'b0; we0 = 1'b0; selram0 = 1'b0; addr0 = 8'h00; wdata0 = 8'h00;
        req1 = 1'b0; we1 = 1'b0; selram1 = 1'b0; addr1 = 8'h00; wdata1 = 8'h00;
        test_reset();
        test_ram_write_read();
        test_rom_read();
        test_addr_boundary();
        test_contention();
        test_rom_write();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
